// File: rtl/mac_accum_frame_if.sv
// Operand/result bundle for mac_accum_frame.
// in_valid qualifies a/b for exactly one cycle; there is no backpressure, so the
// source may present a new sample every cycle and the consumer must take res on
// the single res_valid cycle.
interface mac_accum_frame_if #(
    parameter int A_W   = 8,
    parameter int ACC_W = 16,
    parameter int LEN_W = 8
) ();
    logic signed [A_W-1:0]   a;
    logic signed [A_W-1:0]   b;
    logic                    in_valid;
    logic                    clr;
    logic [LEN_W-1:0]        len;
    logic signed [ACC_W-1:0] acc;
    logic                    of;
    logic                    uf;
    logic signed [ACC_W-1:0] res;
    logic                    res_valid;

    modport master (
        output a, b, in_valid, clr, len,
        input  acc, of, uf, res, res_valid
    );

    modport slave (
        input  a, b, in_valid, clr, len,
        output acc, of, uf, res, res_valid
    );
endinterface

// File: rtl/mac_accum_frame.sv
// Two-stage signed multiply-accumulate with per-frame results, optional
// saturation and sticky overflow/underflow flags.
module mac_accum_frame #(
    parameter int A_W   = 8,
    parameter int ACC_W = 16,
    parameter bit SAT   = 1'b1,
    parameter int LEN_W = 8
) (
    input logic              clk,
    input logic              rst,
    mac_accum_frame_if.slave bus
);
    localparam int P_W = 2 * A_W;
    localparam int S_W = ACC_W + 1;
    localparam logic signed [S_W-1:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [S_W-1:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    // Stage 1: product plus the frame length presented with that sample.
    logic signed [P_W-1:0]   p_q, p_d;
    logic                    p_vld_q, p_vld_d;
    logic [LEN_W-1:0]        p_len_q, p_len_d;

    // Stage 2: accumulator and frame bookkeeping.
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] res_q, res_d;
    logic                    res_valid_q, res_valid_d;
    logic                    of_q, of_d;
    logic                    uf_q, uf_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    in_frame_q, in_frame_d;

    logic signed [P_W-1:0]   a_ext;
    logic signed [P_W-1:0]   b_ext;
    logic signed [S_W-1:0]   base;
    logic signed [S_W-1:0]   sum;
    logic                    pos_ovf;
    logic                    neg_ovf;
    logic signed [ACC_W-1:0] new_acc;
    logic [LEN_W-1:0]        len_eff;
    logic [LEN_W-1:0]        cnt_inc;
    logic                    done;

    always_comb begin
        a_ext   = P_W'(bus.a);
        b_ext   = P_W'(bus.b);
        p_d     = p_q;
        p_vld_d = 1'b0;
        p_len_d = p_len_q;
        if (!bus.clr && bus.in_valid) begin
            p_d     = a_ext * b_ext;
            p_vld_d = 1'b1;
            p_len_d = bus.len;
        end
    end

    // The first sample of a frame starts from zero and owns the frame length.
    always_comb begin
        base    = in_frame_q ? S_W'(acc_q) : '0;
        sum     = base + S_W'(p_q);
        pos_ovf = (sum > ACC_MAX);
        neg_ovf = (sum < ACC_MIN);
        if (SAT && pos_ovf) begin
            new_acc = ACC_MAX[ACC_W-1:0];
        end else if (SAT && neg_ovf) begin
            new_acc = ACC_MIN[ACC_W-1:0];
        end else begin
            new_acc = sum[ACC_W-1:0];
        end
        len_eff = in_frame_q ? len_q : p_len_q;
        cnt_inc = (in_frame_q ? cnt_q : '0) + LEN_W'(1);
        done    = (len_eff != '0) && (cnt_inc == len_eff);
    end

    always_comb begin
        acc_d       = acc_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        of_d        = of_q;
        uf_d        = uf_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        in_frame_d  = in_frame_q;
        if (bus.clr) begin
            acc_d      = '0;
            of_d       = 1'b0;
            uf_d       = 1'b0;
            cnt_d      = '0;
            in_frame_d = 1'b0;
        end else if (p_vld_q) begin
            acc_d = new_acc;
            of_d  = (in_frame_q & of_q) | pos_ovf;
            uf_d  = (in_frame_q & uf_q) | neg_ovf;
            len_d = len_eff;
            if (done) begin
                res_d       = new_acc;
                res_valid_d = 1'b1;
                cnt_d       = '0;
                in_frame_d  = 1'b0;
            end else begin
                // Free-running frames (length 0) never advance the counter.
                cnt_d      = (len_eff == '0) ? '0 : cnt_inc;
                in_frame_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            p_len_q     <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            of_q        <= 1'b0;
            uf_q        <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            in_frame_q  <= 1'b0;
        end else begin
            p_q         <= p_d;
            p_vld_q     <= p_vld_d;
            p_len_q     <= p_len_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            of_q        <= of_d;
            uf_q        <= uf_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            in_frame_q  <= in_frame_d;
        end
    end

    assign bus.acc       = acc_q;
    assign bus.of        = of_q;
    assign bus.uf        = uf_q;
    assign bus.res       = res_q;
    assign bus.res_valid = res_valid_q;
endmodule

// File: tb/tb_mac_accum_frame.sv
// Drives a wrapping and a saturating mac_accum_frame with identical stimulus and
// compares both against a frame-level arithmetic reference model.
module tb_mac_accum_frame;
    localparam int A_W   = 8;
    localparam int ACC_W = 16;
    localparam int LEN_W = 8;
    localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W - 1));
    localparam longint SPAN = longint'(1) << ACC_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_accum_frame_if #(.A_W(A_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus_w ();
    mac_accum_frame_if #(.A_W(A_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus_s ();

    mac_accum_frame #(.A_W(A_W), .ACC_W(ACC_W), .SAT(1'b0), .LEN_W(LEN_W)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w)
    );
    mac_accum_frame #(.A_W(A_W), .ACC_W(ACC_W), .SAT(1'b1), .LEN_W(LEN_W)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s)
    );

    int checks = 0;
    int errors = 0;

    // Reference model, index 0 = wrap instance, 1 = saturating instance.
    longint m_acc [2];
    longint m_res [2];
    bit     m_of  [2];
    bit     m_uf  [2];
    bit     m_rv  [2];
    bit     m_open[2];
    int     m_len [2];
    int     m_cnt [2];
    bit     pend_v;
    int     pend_a, pend_b, pend_len;
    logic [ACC_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic signed [63:0] obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap(input longint s);
        longint v = s;
        while (v > MAXV) v -= SPAN;
        while (v < MINV) v += SPAN;
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_res[k] = 0; m_of[k] = 0; m_uf[k] = 0;
            m_rv[k] = 0; m_open[k] = 0; m_len[k] = 0; m_cnt[k] = 0;
        end
        pend_v = 0;
        exp_q.delete();
    endfunction

    function automatic void model_apply(input int k, input longint p, input int len);
        longint base, s, v;
        if (!m_open[k]) begin
            m_len[k] = len; m_cnt[k] = 0; m_of[k] = 0; m_uf[k] = 0; base = 0;
        end else begin
            base = m_acc[k];
        end
        s = base + p;
        v = s;
        if (s > MAXV) begin
            m_of[k] = 1;
            v = (k == 1) ? MAXV : wrap(s);
        end else if (s < MINV) begin
            m_uf[k] = 1;
            v = (k == 1) ? MINV : wrap(s);
        end
        m_acc[k]  = v;
        m_open[k] = 1;
        if (m_len[k] != 0) begin
            m_cnt[k]++;
            if (m_cnt[k] == m_len[k]) begin
                m_res[k]  = v;
                m_rv[k]   = 1;
                m_open[k] = 0;
                if (k == 1) exp_q.push_back(v[ACC_W-1:0]);
            end
        end
    endfunction

    function automatic void model_edge(input bit v, input bit c, input int sa, input int sb, input int l);
        for (int k = 0; k < 2; k++) m_rv[k] = 0;
        if (c) begin
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = 0; m_of[k] = 0; m_uf[k] = 0; m_open[k] = 0; m_cnt[k] = 0;
            end
            pend_v = 0;
        end else begin
            if (pend_v)
                for (int k = 0; k < 2; k++) model_apply(k, longint'(pend_a) * pend_b, pend_len);
            pend_v = v; pend_a = sa; pend_b = sb; pend_len = l;
        end
    endfunction

    task automatic compare_all();
        check("acc_wrap", bus_w.acc, m_acc[0]);
        check("of_wrap",  bus_w.of,  longint'(m_of[0]));
        check("uf_wrap",  bus_w.uf,  longint'(m_uf[0]));
        check("res_wrap", bus_w.res, m_res[0]);
        check("rv_wrap",  bus_w.res_valid, longint'(m_rv[0]));
        check("acc_sat",  bus_s.acc, m_acc[1]);
        check("of_sat",   bus_s.of,  longint'(m_of[1]));
        check("uf_sat",   bus_s.uf,  longint'(m_uf[1]));
        check("res_sat",  bus_s.res, m_res[1]);
        check("rv_sat",   bus_s.res_valid, longint'(m_rv[1]));
        if (bus_s.res_valid === 1'b1) begin
            check("sb_pending", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("sb_res", bus_s.res, longint'($signed(exp_q.pop_front())));
        end
    endtask

    task automatic drive(input int sa, input int sb, input bit v, input bit c, input int l);
        bus_w.a = A_W'(sa); bus_w.b = A_W'(sb); bus_w.in_valid = v; bus_w.clr = c; bus_w.len = LEN_W'(l);
        bus_s.a = A_W'(sa); bus_s.b = A_W'(sb); bus_s.in_valid = v; bus_s.clr = c; bus_s.len = LEN_W'(l);
    endtask

    task automatic step(input int sa, input int sb, input bit v, input bit c, input int l);
        drive(sa, sb, v, c, l);
        @(posedge clk);
        model_edge(v, c, sa, sb, l);
        #1;
        compare_all();
    endtask

    // Reset is raised between clock edges and checked before any edge can occur.
    task automatic async_reset_check();
        #2;
        rst = 1'b1;
        #1;
        check("rst_acc_w", bus_w.acc, 0);
        check("rst_res_w", bus_w.res, 0);
        check("rst_acc_s", bus_s.acc, 0);
        check("rst_of_s",  bus_s.of, 0);
        check("rst_uf_s",  bus_s.uf, 0);
        check("rst_res_s", bus_s.res, 0);
        check("rst_rv_s",  bus_s.res_valid, 0);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int cur_len;
        int lens[6];
        lens = '{0, 1, 2, 3, 4, 7};
        rst = 1'b1;
        drive(0, 0, 1'b0, 1'b0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_acc", bus_s.acc, 0);
        check("reset_res", bus_s.res, 0);
        check("reset_rv",  bus_s.res_valid, 0);
        check("reset_of",  bus_s.of, 0);
        check("reset_uf",  bus_s.uf, 0);
        rst = 1'b0;

        // Basic frame of four.
        step(3, 5, 1, 0, 4);
        step(-2, 7, 1, 0, 4);
        check("basic_t2", bus_s.acc, 15);
        step(10, 10, 1, 0, 4);
        check("basic_t3", bus_s.acc, 1);
        step(1, 1, 1, 0, 4);
        check("basic_t4", bus_s.acc, 101);
        step(0, 0, 0, 0, 4);
        check("basic_res", bus_s.res, 102);
        check("basic_rv", bus_s.res_valid, 1);
        step(0, 0, 0, 0, 4);
        check("basic_rv_end", bus_s.res_valid, 0);
        check("basic_hold", bus_s.acc, 102);

        // Reset in the middle of a frame, then len=1 frames back to back.
        step(5, 5, 1, 0, 4);
        step(6, 6, 1, 0, 4);
        async_reset_check();
        step(2, 3, 1, 0, 1);
        step(1, 1, 1, 0, 1);
        check("fresh_res", bus_s.res, 6);
        step(2, 2, 1, 0, 1);
        check("len1_res", bus_s.res, 1);
        step(0, 0, 0, 0, 1);
        check("len1_rv", bus_s.res_valid, 1);

        // Positive overflow, free-running.
        step(0, 0, 0, 1, 0);
        repeat (3) step(127, 127, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("pos_sat", bus_s.acc, 32767);
        check("pos_of", bus_s.of, 1);
        check("pos_wrap", bus_w.acc, -17149);
        check("pos_of_w", bus_w.of, 1);

        // Negative overflow, then a positive sample keeps uf sticky.
        step(0, 0, 0, 1, 0);
        repeat (3) step(-128, 127, 1, 0, 0);
        step(-128, -128, 1, 0, 0);
        check("neg_sat", bus_s.acc, -32768);
        check("neg_uf", bus_s.uf, 1);
        step(0, 0, 0, 0, 0);
        check("neg_recover", bus_s.acc, -16384);
        check("neg_sticky", bus_s.uf, 1);

        // Clear with a sample in flight and one presented alongside clr.
        step(0, 0, 0, 1, 4);
        step(9, 9, 1, 0, 4);
        step(8, 8, 1, 0, 4);
        step(7, 7, 1, 1, 4);
        check("clr_acc", bus_s.acc, 0);
        check("clr_rv", bus_s.res_valid, 0);
        step(1, 2, 1, 0, 4);
        step(3, 4, 1, 0, 4);
        step(5, 6, 1, 0, 4);
        step(7, 8, 1, 0, 4);
        step(0, 0, 0, 0, 4);
        check("clr_frame_res", bus_s.res, 100);
        check("clr_frame_rv", bus_s.res_valid, 1);

        // Back-to-back frames; length raised to 3 inside the second frame.
        step(0, 0, 0, 1, 2);
        step(1, 1, 1, 0, 2);
        step(2, 2, 1, 0, 2);
        step(3, 3, 1, 0, 2);
        check("b2b_res1", bus_s.res, 5);
        check("b2b_rv1", bus_s.res_valid, 1);
        step(4, 4, 1, 0, 3);
        check("b2b_gap", bus_s.res_valid, 0);
        step(5, 5, 1, 0, 3);
        check("b2b_res2", bus_s.res, 25);
        check("b2b_rv2", bus_s.res_valid, 1);
        step(6, 6, 1, 0, 3);
        step(7, 7, 1, 0, 3);
        check("b2b_mid3", bus_s.res_valid, 0);
        step(0, 0, 0, 0, 3);
        check("b2b_res3", bus_s.res, 110);

        // Randomized traffic with occasional clears, length changes and resets.
        cur_len = 3;
        for (int i = 0; i < 600; i++) begin
            int sa, sb;
            bit v, c;
            if ($urandom_range(0, 15) == 0) cur_len = lens[$urandom_range(0, 5)];
            sa = int'($urandom_range(0, 255)) - 128;
            sb = int'($urandom_range(0, 255)) - 128;
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 29) == 0);
            step(sa, sb, v, c, cur_len);
            if ($urandom_range(0, 149) == 0) async_reset_check();
        end
        step(0, 0, 0, 0, cur_len);
        step(0, 0, 0, 0, cur_len);
        check("sb_drained", longint'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_accum_frame.md
# mac_accum_frame

Parametrised, two-stage pipelined signed multiply-accumulate engine. It is the next generation of the team's 8x8 MAC and adds:
- configurable operand and accumulator widths;
- selectable saturate or wrap arithmetic;
- sticky overflow/underflow flags;
- frame-based accumulation that reports a result every `len` samples and restarts automatically.

It sits between a sample source that supplies operands with a valid strobe and a consumer of per-frame dot-product results.

## Interface
Parameters:
- A_W, 8, signed operand width.
- ACC_W, 16, accumulator width; must be ≥ 2*A_W.
- SAT, 1, 1 = saturate on overflow, 0 = two's-complement wrap.
- LEN_W, 8, width of the frame-length input.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- a  in  A_W  signed operand.
- b  in  A_W  signed operand.
- in_valid  in  1  a/b valid this cycle.
- clr  in  1  synchronous clear / pipeline flush.
- len  in  LEN_W  samples per frame; 0 = free-running, frame never completes.
- acc  out  ACC_W  running signed accumulator.
- of  out  1  sticky positive-overflow flag for current frame.
- uf  out  1  sticky negative-overflow flag for current frame.
- res  out  ACC_W  last completed frame result, held.
- res_valid  out  1  one-cycle pulse when res is updated.

## Operation
- Stage 1: when in_valid=1, register the product p = a*b (signed, 2*A_W bits) and set p_vld; otherwise p_vld=0.
- Stage 2: when p_vld=1, form sum = base + sext(p) at ACC_W+1 bits.
  - base = 0 if this is the first sample of a frame, else acc.
- Overflow detection:
  - positive overflow when sum > 2^(ACC_W-1)-1: set of;
  - negative overflow when sum < -2^(ACC_W-1): set uf.
- Update rule:
  - SAT=1: acc takes the clamped value (max or min);
  - SAT=0: acc takes sum[ACC_W-1:0].
  - Later samples accumulate from the stored (clamped or wrapped) value.
- Frame tracking:
  - internal counter cnt counts stage-2 updates;
  - len is latched into len_q on the first sample of each frame;
  - changes to len mid-frame are ignored.
- Frame completion:
  - when cnt reaches len_q (len_q ≠ 0), at the same edge: acc and res take the final value, res_valid=1, cnt returns to 0, and the next sample starts a new frame.
  - acc keeps showing the final value until that next sample arrives.
- of/uf: sticky within a frame; cleared on the first sample of the next frame (then set if that sample itself overflows). They remain readable during the res_valid cycle.
- clr=1, highest priority:
  - acc, cnt, of, uf and p_vld go to 0; res_valid=0; res is held.
  - a sample presented with clr=1 is dropped.
  - A product in stage 1 is discarded.
  - The next accepted sample starts a new frame.
- Reset values: acc=0, res=0, res_valid=0, of=0, uf=0, cnt=0, p_vld=0, len_q=0.
- Reset mid-frame: all state returns to the reset values immediately and asynchronously; no partial result is reported.

## Timing
- Latency: a sample with in_valid at cycle t updates acc (and res/res_valid for the last frame sample) at the rising edge ending cycle t+1, visible in cycle t+2.
- Throughput: one sample per cycle, no stalls; back-to-back frames have no bubble.
- res_valid is high exactly one cycle per completed frame.
- Simultaneous completion and first sample of the next frame cannot coincide in stage 2, since stage 2 handles one sample per cycle.
- len=1: every sample produces a result; res_valid may be high on consecutive cycles.
- cnt saturating at 2^LEN_W-1 is impossible because cnt ≤ len_q ≤ 2^LEN_W-1.
- In free-running mode (len_q=0), cnt does not advance and res never updates.

## Test plan
Default parameters, SAT=1 unless noted.
- **Reset:** assert rst mid-stream → all outputs read 0 immediately; first sample after release starts a fresh frame.
- **Basic frame:** len=4, samples (3,5), (-2,7), (10,10), (1,1) on consecutive cycles → acc reads 15, 1, 101, 102 in cycles t+2..t+5; res=102 with a single res_valid pulse in cycle t+5.
- **Positive overflow:** len=0, three samples of (127,127) →
  - SAT=1: acc 16129, 32258, 32767, of=1.
  - SAT=0: final acc -17149, of=1.
- **Negative overflow:** len=0, three samples of (-128,127) → acc -16256, -32512, -32768 with uf=1. Then (-128,-128) → acc -16384, uf stays 1.
- **Clear:** len=4, after two samples assert clr together with in_valid, with one product in flight → acc=0, of=uf=0, no res_valid. Both the clr-cycle sample and the in-flight product are dropped. The next 4 samples form a complete frame.
- **Back-to-back frames:** len=2, four samples (1,1), (2,2), (3,3), (4,4), with len changed to 3 during the second sample → res=5 then res=25, two res_valid pulses two cycles apart. The third frame uses len=3.
